// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 initiator driven by a valid/ready command stream.
// Optional ACCESS timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int BUS_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic                     cmd_write,
  input  logic [BUS_WIDTH*8-1:0]   cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BUS_WIDTH*8-1:0]   rsp_rdata,
  output logic                     rsp_error,
  output logic [ADDRESS_WIDTH-1:0] m_apb_paddr,
  output logic                     m_apb_psel,
  output logic                     m_apb_penable,
  input  logic                     m_apb_pready,
  output logic                     m_apb_pwrite,
  output logic [BUS_WIDTH*8-1:0]   m_apb_pwdata,
  input  logic [BUS_WIDTH*8-1:0]   m_apb_prdata,
  input  logic                     m_apb_pslverror
);
  localparam int DW = BUS_WIDTH * 8;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(BUS_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [DW-1:0]            pwdata_q, pwdata_d;
  logic [DW-1:0]            rdata_q, rdata_d;
  logic                     err_q, err_d;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]              cnt_q, cnt_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d  = SETUP;
        paddr_d  = cmd_addr & ADDR_MASK;
        pwrite_d = cmd_write;
        pwdata_d = cmd_wdata;
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: if (m_apb_pready) begin
        state_d = RESP;
        rdata_d = pwrite_q ? '0 : m_apb_prdata;
        err_d   = m_apb_pslverror;
      end
`ifdef APB_MASTER_TIMEOUT_EN
      else if (cnt_q == CNT_LAST) begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + 16'd1;
`endif
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // cmd_ready is gated by rst so it reads 0 throughout reset, even once IDLE is reached
  always_comb begin
    cmd_ready     = state_q == IDLE && !rst;
    m_apb_psel    = state_q == SETUP || state_q == ACCESS;
    m_apb_penable = state_q == ACCESS;
    rsp_valid     = state_q == RESP;
  end
  assign m_apb_paddr  = paddr_q;
  assign m_apb_pwrite = pwrite_q;
  assign m_apb_pwdata = pwdata_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_error    = err_q;
endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB3 initiator. It converts a valid/ready command stream (address, direction, write data) into one APB3 transfer at a time and returns a response beat (read data, error flag). It sits on the initiator side of an APB3 interface, facing responders such as apb_rom, so that hardware engines can issue APB transfers without a CPU.

## Interface
- ADDRESS_WIDTH, 32, APB address width in bits.
- BUS_WIDTH, 4, data bus width in bytes; the data width is BUS_WIDTH*8.
- TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles before an abort. Used only with APB_MASTER_TIMEOUT_EN. Legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_addr  in  ADDRESS_WIDTH  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  BUS_WIDTH*8  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high.
- rsp_rdata  out  BUS_WIDTH*8  read data; 0 for writes and aborts.
- rsp_error  out  1  PSLVERROR was sampled, or the transfer timed out.
- m_apb_paddr  out  ADDRESS_WIDTH  APB address.
- m_apb_psel  out  1  APB select (single responder).
- m_apb_penable  out  1  APB enable.
- m_apb_pready  in  1  responder ready.
- m_apb_pwrite  out  1  APB direction.
- m_apb_pwdata  out  BUS_WIDTH*8  APB write data.
- m_apb_prdata  in  BUS_WIDTH*8  APB read data.
- m_apb_pslverror  in  1  responder error.

## Operation
- State machine has four states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE
  - cmd_ready = 1; all other control outputs are 0.
  - On a handshake: latch the command into m_apb_paddr, m_apb_pwrite and m_apb_pwdata, then go to SETUP.
  - The low log2(BUS_WIDTH) bits of m_apb_paddr are forced to 0.
- SETUP
  - psel = 1, penable = 0.
  - Always advances to ACCESS after one cycle.
- ACCESS
  - psel = 1, penable = 1.
  - If pready = 1 on a clock edge:
    - capture prdata (reads only; writes return 0) and pslverror;
    - drop psel and penable;
    - go to RESP.
  - Otherwise stay in ACCESS. Address, direction and write data are held stable.
- RESP
  - rsp_valid = 1; rsp_rdata and rsp_error are held stable.
  - On rsp_ready: go to IDLE.
- cmd_ready is low in SETUP, ACCESS and RESP. Only one transfer is ever outstanding.
- m_apb_paddr, m_apb_pwrite and m_apb_pwdata keep their last values outside a transfer. Responders must qualify them with psel.
- prdata and pslverror are ignored unless the state is ACCESS and pready = 1.

## Timing
- Reset values:
  - cmd_ready = 0 during reset, then 1 from the first cycle after reset deasserts.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - m_apb_psel = 0, m_apb_penable = 0, m_apb_paddr = 0, m_apb_pwrite = 0, m_apb_pwdata = 0.
- Latency, counted from the handshake at edge 0:
  - SETUP is visible in cycle 1.
  - ACCESS is visible in cycle 2.
  - With pready = 1 in cycle 2, rsp_valid is high in cycle 3.
  - Each wait state adds one cycle.
- Minimum issue interval is 4 cycles per transfer, reached when pready has no waits and rsp_ready is held high.
- rsp_ready high while in RESP returns the block to IDLE on the next edge. A new command can be accepted one cycle later.
- Reset asserted mid-transfer, including during ACCESS:
  - psel and penable drop at the next edge;
  - no response is produced;
  - the block returns to IDLE.
- cmd_valid held high continuously: commands are issued back to back, each one accepted only in IDLE.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to ACCESS and increments on each cycle in ACCESS without pready.
  - When the count reaches TIMEOUT_CYCLES, the transfer aborts: psel and penable drop, the block goes to RESP with rsp_error = 1 and rsp_rdata = 0.
  - pready arriving on the same cycle as the final count wins; the transfer completes normally.
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter is built; ACCESS waits indefinitely for pready.
  - rsp_error reflects only pslverror.

## Test plan
- Read, no wait states: cmd addr 0x0000_0010, prdata 0xDEADBEEF with pready in cycle 2 -> psel in cycles 1–2, penable in cycle 2, rsp_valid in cycle 3 with rsp_rdata 0xDEADBEEF and rsp_error 0.
- Write with 3 wait states: addr 0x0000_0007, wdata 0x12345678 -> paddr 0x0000_0004 and pwdata stable through SETUP plus 4 ACCESS cycles; rsp_rdata 0, rsp_error 0.
- Responder error: pslverror = 1 with pready on a read -> rsp_error 1; the next command proceeds normally.
- Timeout (macro on, TIMEOUT_CYCLES = 8, pready tied 0) -> abort after 8 ACCESS cycles with rsp_error 1 and rsp_rdata 0. With the macro off, the bench confirms no response is produced after 1000 cycles.
- Back-pressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp data stable for all 5 cycles, cmd_ready stays 0, then the block returns to IDLE.
- Reset mid-ACCESS (pready = 0, rst pulsed for 1 cycle) -> psel and penable are 0 at the next edge, rsp_valid never rises, cmd_ready is 1 one cycle after rst deasserts.
